// File: rtl/rs_dispatcher_pkg.sv
// rs_dispatcher_pkg: tag encodings and reservation-station count shared by the superscalar front end.
package rs_dispatcher_pkg;
  localparam int NUM_RS = 3;
  typedef logic [1:0] tag_t;
  localparam tag_t TAG_ALU0  = 2'b00;
  localparam tag_t TAG_ALU1  = 2'b01;
  localparam tag_t TAG_ALU2  = 2'b10;
  localparam tag_t TAG_READY = 2'b11;
endpackage

// File: rtl/rs_dispatcher_reg_status_table.sv
// rs_dispatcher_reg_status_table: per-architectural-register producer tags with CDB clear and flush.
module rs_dispatcher_reg_status_table
  import rs_dispatcher_pkg::*;
#(
  parameter int NUM_ARCH_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output tag_t              rs1_tag,
  output tag_t              rs2_tag,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  tag_t              wr_tag,
  input  logic [NUM_RS-1:0] cdb_valid
);
  tag_t tags_q [NUM_ARCH_REGS];
  tag_t tags_d [NUM_ARCH_REGS];
  logic [3:0] cdb_hit;
  assign cdb_hit = {1'b0, cdb_valid};
  // A dispatch write lands after the CDB clear so a new producer wins over a retiring one.
  always_comb begin
    for (int i = 0; i < NUM_ARCH_REGS; i++)
      tags_d[i] = (flush || i == 0 || cdb_hit[tags_q[i]]) ? TAG_READY : tags_q[i];
    if (wr_en && !flush && wr_addr != 5'd0) tags_d[wr_addr] = wr_tag;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NUM_ARCH_REGS; i++) tags_q[i] <= TAG_READY;
    else tags_q <= tags_d;
  assign rs1_tag = rs1_addr == 5'd0 ? TAG_READY : tags_q[rs1_addr];
  assign rs2_tag = rs2_addr == 5'd0 ? TAG_READY : tags_q[rs2_addr];
endmodule

// File: rtl/rs_dispatcher.sv
// rs_dispatcher: one-entry instruction buffer that resolves operand tags and issues to the first ready RS.
module rs_dispatcher
  import rs_dispatcher_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int PHYS_REG_ADDR_WIDTH = 6,
  parameter int NUM_ARCH_REGS       = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [4:0]                     in_rs1,
  input  logic [4:0]                     in_rs2,
  input  logic [4:0]                     in_rd,
  input  logic                           in_writes_rd,
  input  logic [DATA_WIDTH-1:0]          in_rs1_data,
  input  logic [DATA_WIDTH-1:0]          in_rs2_data,
  input  logic [DATA_WIDTH-1:0]          in_imm,
  input  logic                           in_use_imm,
  input  logic                           in_is_store,
  input  logic [10:0]                    in_control_signals,
  input  logic [DATA_WIDTH-1:0]          in_pc,
  input  logic [DATA_WIDTH-1:0]          in_pc_value_at_prediction,
  input  logic [2:0]                     in_branch_sel,
  input  logic                           in_branch_prediction,
  output logic                           dispatch_valid_0,
  input  logic                           dispatch_ready_0,
  output logic [DATA_WIDTH-1:0]          operand_a_data_0,
  output logic [DATA_WIDTH-1:0]          operand_b_data_0,
  output logic [1:0]                     operand_a_tag_0,
  output logic [1:0]                     operand_b_tag_0,
  output logic [10:0]                    control_signals_0,
  output logic [DATA_WIDTH-1:0]          pc_0,
  output logic [PHYS_REG_ADDR_WIDTH-1:0] rd_phys_addr_0,
  output logic [DATA_WIDTH-1:0]          pc_value_at_prediction_0,
  output logic [2:0]                     branch_sel_0,
  output logic                           branch_prediction_0,
  output logic [DATA_WIDTH-1:0]          store_data_0,
  output logic                           dispatch_valid_1,
  input  logic                           dispatch_ready_1,
  output logic [DATA_WIDTH-1:0]          operand_a_data_1,
  output logic [DATA_WIDTH-1:0]          operand_b_data_1,
  output logic [1:0]                     operand_a_tag_1,
  output logic [1:0]                     operand_b_tag_1,
  output logic [10:0]                    control_signals_1,
  output logic [DATA_WIDTH-1:0]          pc_1,
  output logic [PHYS_REG_ADDR_WIDTH-1:0] rd_phys_addr_1,
  output logic [DATA_WIDTH-1:0]          pc_value_at_prediction_1,
  output logic [2:0]                     branch_sel_1,
  output logic                           branch_prediction_1,
  output logic [DATA_WIDTH-1:0]          store_data_1,
  output logic                           dispatch_valid_2,
  input  logic                           dispatch_ready_2,
  output logic [DATA_WIDTH-1:0]          operand_a_data_2,
  output logic [DATA_WIDTH-1:0]          operand_b_data_2,
  output logic [1:0]                     operand_a_tag_2,
  output logic [1:0]                     operand_b_tag_2,
  output logic [10:0]                    control_signals_2,
  output logic [DATA_WIDTH-1:0]          pc_2,
  output logic [PHYS_REG_ADDR_WIDTH-1:0] rd_phys_addr_2,
  output logic [DATA_WIDTH-1:0]          pc_value_at_prediction_2,
  output logic [2:0]                     branch_sel_2,
  output logic                           branch_prediction_2,
  output logic [DATA_WIDTH-1:0]          store_data_2,
  input  logic                           cdb_valid_0,
  input  logic                           cdb_valid_1,
  input  logic                           cdb_valid_2,
  input  logic [DATA_WIDTH-1:0]          cdb_data_0,
  input  logic [DATA_WIDTH-1:0]          cdb_data_1,
  input  logic [DATA_WIDTH-1:0]          cdb_data_2,
  input  logic                           flush
);
  typedef struct packed {
    logic [4:0]            rs1, rs2, rd;
    logic                  writes_rd, use_imm, is_store;
    logic [DATA_WIDTH-1:0] rs1_data, rs2_data, imm;
    logic [10:0]           ctrl;
    logic [DATA_WIDTH-1:0] pc, pc_pred;
    logic [2:0]            branch_sel;
    logic                  branch_pred;
  } buf_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0]          a_data, b_data;
    tag_t                           a_tag, b_tag;
    logic [10:0]                    ctrl;
    logic [DATA_WIDTH-1:0]          pc;
    logic [PHYS_REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]          pc_pred;
    logic [2:0]                     branch_sel;
    logic                           branch_pred;
    logic [DATA_WIDTH-1:0]          store_data;
  } chan_t;
  buf_t buf_q, buf_d;
  logic buf_valid_q, buf_valid_d;
  tag_t rs1_tag, rs2_tag, a_tag, s_tag, sel;
  logic [DATA_WIDTH-1:0] a_data, s_data;
  logic [DATA_WIDTH-1:0] cdb_data [4];
  logic [3:0] cdb_v;
  logic [2:0] ready, go;
  logic stall, dispatched, capture;
  chan_t payload;
  chan_t chan [NUM_RS];
  assign cdb_data[0] = cdb_data_0;
  assign cdb_data[1] = cdb_data_1;
  assign cdb_data[2] = cdb_data_2;
  assign cdb_data[3] = '0;
  assign cdb_v = {1'b0, cdb_valid_2, cdb_valid_1, cdb_valid_0};
  assign ready = {dispatch_ready_2, dispatch_ready_1, dispatch_ready_0};
  rs_dispatcher_reg_status_table #(.NUM_ARCH_REGS(NUM_ARCH_REGS)) u_table (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .rs1_addr (buf_q.rs1),
    .rs2_addr (buf_q.rs2),
    .rs1_tag  (rs1_tag),
    .rs2_tag  (rs2_tag),
    .wr_en    (dispatched && buf_q.writes_rd),
    .wr_addr  (buf_q.rd),
    .wr_tag   (sel),
    .cdb_valid(cdb_v[2:0])
  );
  // cdb_v[3] is zero, so a ready tag never takes the bypass path.
  always_comb begin
    a_data = rs1_tag == TAG_READY ? buf_q.rs1_data : cdb_v[rs1_tag] ? cdb_data[rs1_tag] : '0;
    a_tag = cdb_v[rs1_tag] ? TAG_READY : rs1_tag;
    s_data = rs2_tag == TAG_READY ? buf_q.rs2_data : cdb_v[rs2_tag] ? cdb_data[rs2_tag] : '0;
    s_tag = cdb_v[rs2_tag] ? TAG_READY : rs2_tag;
    stall = buf_q.is_store && s_tag != TAG_READY;
    sel = ready[0] ? TAG_ALU0 : ready[1] ? TAG_ALU1 : TAG_ALU2;
    dispatched = buf_valid_q && !flush && !stall && |ready;
    go = dispatched ? 3'b001 << sel : 3'b000;
    in_ready = !buf_valid_q || dispatched;
    capture = in_valid && in_ready && !flush;
    buf_valid_d = flush ? 1'b0 : capture ? 1'b1 : dispatched ? 1'b0 : buf_valid_q;
    buf_d = capture ? '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, writes_rd: in_writes_rd,
                        use_imm: in_use_imm, is_store: in_is_store, rs1_data: in_rs1_data,
                        rs2_data: in_rs2_data, imm: in_imm, ctrl: in_control_signals, pc: in_pc,
                        pc_pred: in_pc_value_at_prediction, branch_sel: in_branch_sel,
                        branch_pred: in_branch_prediction} : buf_q;
    payload = '{a_data: a_data, b_data: buf_q.use_imm ? buf_q.imm : s_data, a_tag: a_tag,
                b_tag: buf_q.use_imm ? TAG_READY : s_tag, ctrl: buf_q.ctrl, pc: buf_q.pc,
                rd: PHYS_REG_ADDR_WIDTH'(buf_q.rd), pc_pred: buf_q.pc_pred,
                branch_sel: buf_q.branch_sel, branch_pred: buf_q.branch_pred, store_data: s_data};
    for (int k = 0; k < NUM_RS; k++) chan[k] = go[k] ? payload : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_q <= buf_d;
    end
  assign {dispatch_valid_2, dispatch_valid_1, dispatch_valid_0} = go;
  assign {operand_a_data_0, operand_b_data_0, operand_a_tag_0, operand_b_tag_0, control_signals_0, pc_0,
          rd_phys_addr_0, pc_value_at_prediction_0, branch_sel_0, branch_prediction_0, store_data_0} = chan[0];
  assign {operand_a_data_1, operand_b_data_1, operand_a_tag_1, operand_b_tag_1, control_signals_1, pc_1,
          rd_phys_addr_1, pc_value_at_prediction_1, branch_sel_1, branch_prediction_1, store_data_1} = chan[1];
  assign {operand_a_data_2, operand_b_data_2, operand_a_tag_2, operand_b_tag_2, control_signals_2, pc_2,
          rd_phys_addr_2, pc_value_at_prediction_2, branch_sel_2, branch_prediction_2, store_data_2} = chan[2];
endmodule

// File: tb/tb_rs_dispatcher.sv
// tb_rs_dispatcher: directed dispatch, bypass, stall, flush and reset scenarios with hand-computed expectations.
module tb_rs_dispatcher;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [4:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic in_writes_rd = 1'b0, in_use_imm = 1'b0, in_is_store = 1'b0, in_branch_prediction = 1'b0;
  logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0, in_pc = '0, in_pc_value_at_prediction = '0;
  logic [10:0] in_control_signals = '0;
  logic [2:0] in_branch_sel = '0;
  logic dispatch_valid_0, dispatch_valid_1, dispatch_valid_2;
  logic dispatch_ready_0 = 1'b1, dispatch_ready_1 = 1'b1, dispatch_ready_2 = 1'b1;
  logic [31:0] operand_a_data_0, operand_a_data_1, operand_a_data_2;
  logic [31:0] operand_b_data_0, operand_b_data_1, operand_b_data_2;
  logic [1:0] operand_a_tag_0, operand_a_tag_1, operand_a_tag_2;
  logic [1:0] operand_b_tag_0, operand_b_tag_1, operand_b_tag_2;
  logic [10:0] control_signals_0, control_signals_1, control_signals_2;
  logic [31:0] pc_0, pc_1, pc_2, store_data_0, store_data_1, store_data_2;
  logic [31:0] pc_value_at_prediction_0, pc_value_at_prediction_1, pc_value_at_prediction_2;
  logic [5:0] rd_phys_addr_0, rd_phys_addr_1, rd_phys_addr_2;
  logic [2:0] branch_sel_0, branch_sel_1, branch_sel_2;
  logic branch_prediction_0, branch_prediction_1, branch_prediction_2;
  logic cdb_valid_0 = 1'b0, cdb_valid_1 = 1'b0, cdb_valid_2 = 1'b0;
  logic [31:0] cdb_data_0 = '0, cdb_data_1 = '0, cdb_data_2 = '0;
  int n_cmp = 0, n_err = 0;
  logic [2:0] dv;
  assign dv = {dispatch_valid_2, dispatch_valid_1, dispatch_valid_0};
  always #5 clk = ~clk;
  rs_dispatcher dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_writes_rd(in_writes_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_is_store(in_is_store), .in_control_signals(in_control_signals),
    .in_pc(in_pc), .in_pc_value_at_prediction(in_pc_value_at_prediction),
    .in_branch_sel(in_branch_sel), .in_branch_prediction(in_branch_prediction),
    .dispatch_valid_0(dispatch_valid_0), .dispatch_ready_0(dispatch_ready_0),
    .operand_a_data_0(operand_a_data_0), .operand_b_data_0(operand_b_data_0),
    .operand_a_tag_0(operand_a_tag_0), .operand_b_tag_0(operand_b_tag_0),
    .control_signals_0(control_signals_0), .pc_0(pc_0), .rd_phys_addr_0(rd_phys_addr_0),
    .pc_value_at_prediction_0(pc_value_at_prediction_0), .branch_sel_0(branch_sel_0),
    .branch_prediction_0(branch_prediction_0), .store_data_0(store_data_0),
    .dispatch_valid_1(dispatch_valid_1), .dispatch_ready_1(dispatch_ready_1),
    .operand_a_data_1(operand_a_data_1), .operand_b_data_1(operand_b_data_1),
    .operand_a_tag_1(operand_a_tag_1), .operand_b_tag_1(operand_b_tag_1),
    .control_signals_1(control_signals_1), .pc_1(pc_1), .rd_phys_addr_1(rd_phys_addr_1),
    .pc_value_at_prediction_1(pc_value_at_prediction_1), .branch_sel_1(branch_sel_1),
    .branch_prediction_1(branch_prediction_1), .store_data_1(store_data_1),
    .dispatch_valid_2(dispatch_valid_2), .dispatch_ready_2(dispatch_ready_2),
    .operand_a_data_2(operand_a_data_2), .operand_b_data_2(operand_b_data_2),
    .operand_a_tag_2(operand_a_tag_2), .operand_b_tag_2(operand_b_tag_2),
    .control_signals_2(control_signals_2), .pc_2(pc_2), .rd_phys_addr_2(rd_phys_addr_2),
    .pc_value_at_prediction_2(pc_value_at_prediction_2), .branch_sel_2(branch_sel_2),
    .branch_prediction_2(branch_prediction_2), .store_data_2(store_data_2),
    .cdb_valid_0(cdb_valid_0), .cdb_valid_1(cdb_valid_1), .cdb_valid_2(cdb_valid_2),
    .cdb_data_0(cdb_data_0), .cdb_data_1(cdb_data_1), .cdb_data_2(cdb_data_2),
    .flush(flush)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input logic wr,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic ui, input logic st, input logic [31:0] pc);
    in_valid = 1'b1;
    in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_writes_rd = wr;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_use_imm = ui; in_is_store = st;
    in_pc = pc; in_control_signals = 11'(pc >> 2); in_pc_value_at_prediction = pc + 32'd4;
    in_branch_sel = pc[4:2]; in_branch_prediction = pc[2];
  endtask
  initial begin
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_valids", dv, 0);
    check("rst_a_data0", operand_a_data_0, 0);
    check("rst_store0", store_data_0, 0);
    tick;
    reset = 1'b0;
    drive(1, 2, 3, 1, 'h11, 'h22, 0, 0, 0, 'h100);
    tick;
    drive(3, 1, 4, 1, 'h33, 'h11, 0, 0, 0, 'h104);
    #1;
    check("i1_valids", dv, 3'b001);
    check("i1_a_tag", operand_a_tag_0, 3);
    check("i1_a_data", operand_a_data_0, 'h11);
    check("i1_b_tag", operand_b_tag_0, 3);
    check("i1_b_data", operand_b_data_0, 'h22);
    check("i1_rd", rd_phys_addr_0, 3);
    check("i1_ctrl", control_signals_0, 'h40);
    check("i1_pcpred", pc_value_at_prediction_0, 'h104);
    check("i1_in_ready", in_ready, 1);
    tick;
    {dispatch_ready_2, dispatch_ready_1, dispatch_ready_0} = 3'b110;
    drive(3, 4, 5, 1, 'h66, 'h44, 0, 0, 0, 'h108);
    #1;
    check("i2_valids", dv, 3'b010);
    check("i2_a_tag", operand_a_tag_1, 0);
    check("i2_a_data", operand_a_data_1, 0);
    check("i2_b_tag", operand_b_tag_1, 3);
    check("i2_b_data", operand_b_data_1, 'h11);
    check("i2_rd", rd_phys_addr_1, 4);
    check("i2_idle_ch0", operand_a_data_0, 0);
    tick;
    {dispatch_ready_2, dispatch_ready_1, dispatch_ready_0} = 3'b111;
    cdb_valid_0 = 1'b1; cdb_data_0 = 'h55;
    drive(3, 0, 6, 1, 'h77, 'h99, 0, 0, 0, 'h10c);
    #1;
    check("i3_valids", dv, 3'b001);
    check("i3_a_tag", operand_a_tag_0, 3);
    check("i3_a_data", operand_a_data_0, 'h55);
    check("i3_b_tag", operand_b_tag_0, 1);
    check("i3_b_data", operand_b_data_0, 0);
    tick;
    cdb_valid_0 = 1'b0;
    drive(5, 6, 7, 1, 0, 0, 'h1234, 1, 0, 'h110);
    #1;
    check("i4_valids", dv, 3'b001);
    check("i4_a_tag", operand_a_tag_0, 3);
    check("i4_a_data", operand_a_data_0, 'h77);
    check("i4_b_x0_tag", operand_b_tag_0, 3);
    check("i4_b_x0_data", operand_b_data_0, 'h99);
    tick;
    {dispatch_ready_2, dispatch_ready_1, dispatch_ready_0} = 3'b000;
    drive(1, 7, 0, 0, 'hab, 'hcd, 'h8, 1, 1, 'h200);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("i5_hold_valids", dv, 0);
      check("i5_hold_in_ready", in_ready, 0);
      tick;
    end
    dispatch_ready_2 = 1'b1;
    #1;
    check("i5_valids", dv, 3'b100);
    check("i5_a_tag", operand_a_tag_2, 0);
    check("i5_a_data", operand_a_data_2, 0);
    check("i5_b_tag", operand_b_tag_2, 3);
    check("i5_b_imm", operand_b_data_2, 'h1234);
    check("i5_rd", rd_phys_addr_2, 7);
    check("i5_pc", pc_2, 'h110);
    check("i5_bsel", branch_sel_2, 4);
    check("i5_in_ready", in_ready, 1);
    tick;
    {dispatch_ready_2, dispatch_ready_1, dispatch_ready_0} = 3'b111;
    in_valid = 1'b0;
    #1;
    check("st_stall_valids", dv, 0);
    check("st_stall_in_ready", in_ready, 0);
    tick;
    check("st_stall2_valids", dv, 0);
    cdb_valid_2 = 1'b1; cdb_data_2 = 'hcafe;
    #1;
    check("st_valids", dv, 3'b001);
    check("st_store_data", store_data_0, 'hcafe);
    check("st_b_imm", operand_b_data_0, 'h8);
    check("st_a_data", operand_a_data_0, 'hab);
    check("st_rd", rd_phys_addr_0, 0);
    tick;
    cdb_valid_2 = 1'b0;
    {dispatch_ready_2, dispatch_ready_1, dispatch_ready_0} = 3'b000;
    drive(4, 5, 8, 1, 1, 2, 0, 0, 0, 'h300);
    tick;
    in_valid = 1'b0;
    #1;
    check("fl_pre_valids", dv, 0);
    check("fl_pre_in_ready", in_ready, 0);
    flush = 1'b1;
    {dispatch_ready_2, dispatch_ready_1, dispatch_ready_0} = 3'b111;
    drive(1, 2, 9, 1, 3, 4, 0, 0, 0, 'h304);
    #1;
    check("fl_valids", dv, 0);
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_post_valids", dv, 0);
    check("fl_post_in_ready", in_ready, 1);
    drive(4, 5, 9, 1, 'ha, 'hb, 0, 0, 0, 'h400);
    tick;
    in_valid = 1'b0;
    #1;
    check("fl_tbl_valids", dv, 3'b001);
    check("fl_tbl_a_tag", operand_a_tag_0, 3);
    check("fl_tbl_a_data", operand_a_data_0, 'ha);
    check("fl_tbl_b_tag", operand_b_tag_0, 3);
    check("fl_tbl_b_data", operand_b_data_0, 'hb);
    tick;
    drive(1, 9, 0, 0, 'h1, 'h2, 'h4, 1, 1, 'h500);
    tick;
    in_valid = 1'b0;
    #1;
    check("rs_stall_valids", dv, 0);
    #2;
    reset = 1'b1;
    #1;
    check("rs_valids", dv, 0);
    check("rs_a_data0", operand_a_data_0, 0);
    check("rs_b_data0", operand_b_data_0, 0);
    check("rs_store0", store_data_0, 0);
    check("rs_in_ready", in_ready, 1);
    tick;
    reset = 1'b0;
    #1;
    check("rs_post_valids", dv, 0);
    check("rs_post_in_ready", in_ready, 1);
    drive(1, 9, 0, 0, 'h1, 'h2, 'h4, 1, 1, 'h600);
    tick;
    in_valid = 1'b0;
    #1;
    check("rs_tbl_valids", dv, 3'b001);
    check("rs_tbl_store", store_data_0, 'h2);
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
